// File: rtl/input_handler.sv
// Button synchroniser/debouncer and once-per-frame player motion for graphics_driver.
// Walk left/right with edge saturation; vertical GROUND/ASCEND/DESCEND jump state machine.
module input_handler #(
  parameter int DEBOUNCE_CYCLES   = 1471400,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1,
  parameter int SCREEN_W          = 1680,
  parameter int PLAYER_W          = 32,
  parameter int X_START           = 824,
  parameter int WALK_SPEED        = 4,
  parameter int JUMP_V            = 12,
  parameter int GRAVITY           = 1,
  parameter int MAX_FALL          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left_button,
  input  logic        right_button,
  input  logic        jump,
  input  logic        refresh,
  output logic [10:0] player_x,
  output logic [9:0]  player_y,
  output logic        airborne,
  output logic        update_strobe,
  output logic [2:0]  btn_db
);

  localparam int X_MAX = SCREEN_W - PLAYER_W;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {GROUND, ASCEND, DESCEND} state_t;

  state_t           state;
  logic [3:0]       sync1, sync2;
  logic             refresh_q;
  logic             jump_prev;
  logic             jump_req;
  logic [7:0]       vy;
  logic [CNT_W-1:0] db_cnt [3];

  logic [2:0]  btn_lvl;
  logic        frame_tick;
  logic        jump_edge;
  logic        jump_take;
  logic [11:0] x_wide;
  logic [10:0] x_next;
  logic [10:0] y_up;
  logic [8:0]  vy_inc;
  logic [7:0]  vn;

  // Bit order: {refresh, jump, right, left}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= '0;
      sync2     <= '0;
      refresh_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage shift register.
      sync1     <= {refresh, jump, right_button, left_button};
      sync2     <= sync1;
      refresh_q <= sync2[3];
    end
  end

  assign btn_lvl    = BUTTON_ACTIVE_LOW ? ~sync2[2:0] : sync2[2:0];
  assign frame_tick = sync2[3] & ~refresh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (btn_lvl[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          btn_db[i] <= ~btn_db[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign jump_edge = btn_db[2] & ~jump_prev;
  // A press landing on the tick cycle itself is still honoured by this tick.
  assign jump_take = jump_req | jump_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_prev <= 1'b0;
      jump_req  <= 1'b0;
    end else begin
      jump_prev <= btn_db[2];
      if (frame_tick)     jump_req <= 1'b0;
      else if (jump_edge) jump_req <= 1'b1;
    end
  end

  // 12-bit arithmetic so neither edge can wrap.
  always_comb begin
    x_wide = {1'b0, player_x};
    x_next = player_x;
    if (btn_db[0] && !btn_db[1]) begin
      x_next = (x_wide < 12'(WALK_SPEED)) ? 11'd0 : 11'(x_wide - 12'(WALK_SPEED));
    end else if (btn_db[1] && !btn_db[0]) begin
      x_next = (x_wide + 12'(WALK_SPEED) > 12'(X_MAX)) ? 11'(X_MAX)
                                                     : 11'(x_wide + 12'(WALK_SPEED));
    end
  end

  assign y_up   = {1'b0, player_y} + 11'(vy);
  assign vy_inc = {1'b0, vy} + 9'(GRAVITY);
  assign vn     = (vy_inc > 9'(MAX_FALL)) ? 8'(MAX_FALL) : vy_inc[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= GROUND;
      player_x      <= 11'(X_START);
      player_y      <= '0;
      vy            <= '0;
      airborne      <= 1'b0;
      update_strobe <= 1'b0;
    end else begin
      update_strobe <= frame_tick;
      if (frame_tick) begin
        player_x <= x_next;
        case (state)
          GROUND: begin
            if (jump_take) begin
              state    <= ASCEND;
              vy       <= 8'(JUMP_V);
              airborne <= 1'b1;
            end
          end
          ASCEND: begin
            player_y <= y_up[10] ? 10'd1023 : y_up[9:0];
            if (vy <= 8'(GRAVITY)) begin
              vy    <= '0;
              state <= DESCEND;
            end else begin
              vy <= vy - 8'(GRAVITY);
            end
          end
          DESCEND: begin
            if ({1'b0, player_y} <= 11'(vn)) begin
              player_y <= '0;
              vy       <= '0;
              state    <= GROUND;
              airborne <= 1'b0;
            end else begin
              player_y <= player_y - 10'(vn);
              vy       <= vn;
            end
          end
          default: state <= GROUND;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_input_handler.sv
// Scoreboard bench for input_handler: a small behavioural model predicts each frame's
// player state, which is queued at the refresh edge and compared when update_strobe fires.
module tb_input_handler;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        left_button = 1'b1;
  logic        right_button = 1'b1;
  logic        jump = 1'b1;
  logic        refresh = 1'b0;
  logic [10:0] player_x;
  logic [9:0]  player_y;
  logic        airborne;
  logic        update_strobe;
  logic [2:0]  btn_db;

  input_handler #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .left_button(left_button), .right_button(right_button),
    .jump(jump), .refresh(refresh), .player_x(player_x), .player_y(player_y),
    .airborne(airborne), .update_strobe(update_strobe), .btn_db(btn_db)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        air;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  int   n_checks = 0;
  int   n_errors = 0;
  int   strobe_cnt = 0;

  // Model state: mst 0 = ground, 1 = ascend, 2 = descend.
  int mx, my, mvy, mst;
  bit m_left, m_right, m_jreq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && update_strobe) begin
      strobe_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e_pop = sb.pop_front();
        check("sb_x", 32'(player_x), 32'(e_pop.x));
        check("sb_y", 32'(player_y), 32'(e_pop.y));
        check("sb_air", 32'(airborne), 32'(e_pop.air));
      end
    end
  end

  task automatic model_reset();
    mx = 824; my = 0; mvy = 0; mst = 0; m_jreq = 0;
    m_left = 0; m_right = 0;
  endtask

  task automatic model_step();
    int vn;
    if (m_left && !m_right)      mx = (mx < 4) ? 0 : mx - 4;
    else if (m_right && !m_left) mx = (mx + 4 > 1648) ? 1648 : mx + 4;
    case (mst)
      0: if (m_jreq) begin mst = 1; mvy = 12; end
      1: begin
        my = my + mvy;
        if (mvy <= 1) begin mvy = 0; mst = 2; end
        else mvy = mvy - 1;
      end
      default: begin
        vn = (mvy + 1 > 16) ? 16 : mvy + 1;
        if (my <= vn) begin my = 0; mvy = 0; mst = 0; end
        else begin my = my - vn; mvy = vn; end
      end
    endcase
    m_jreq = 0;
  endtask

  task automatic frame();
    int start;
    exp_t e;
    model_step();
    e.x = 11'(mx); e.y = 10'(my); e.air = (mst != 0);
    sb.push_back(e);
    @(posedge clk); #1;
    start = strobe_cnt;
    refresh = 1'b1;
    for (int i = 0; i < 12 && strobe_cnt == start; i++) @(posedge clk);
    if (strobe_cnt == start) begin
      check("strobe_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    #1 refresh = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic set_pins(input bit l, input bit r);
    @(posedge clk); #1;
    left_button = ~l;
    right_button = ~r;
    repeat (DB + 8) @(posedge clk);
    m_left = l; m_right = r;
  endtask

  task automatic press_jump();
    @(posedge clk); #1 jump = 1'b0;
    repeat (DB + 8) @(posedge clk);
    #1 jump = 1'b1;
    repeat (DB + 8) @(posedge clk);
    m_jreq = 1;
  endtask

  initial begin
    int s0;
    model_reset();

    // Reset state, checked while reset is held and after release.
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(player_x), 32'd824);
    check("rst_y", 32'(player_y), 32'd0);
    check("rst_air", 32'(airborne), 32'd0);
    check("rst_btn", 32'(btn_db), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("idle_strobes", 32'(strobe_cnt), 32'd0);
    check("idle_x", 32'(player_x), 32'd824);
    check("idle_btn", 32'(btn_db), 32'd0);

    // Short glitch on right is rejected.
    @(posedge clk); #1 right_button = 1'b0;
    repeat (2) @(posedge clk);
    #1 right_button = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("glitch_btn", 32'(btn_db), 32'd0);
    frames(5);
    check("glitch_x", 32'(player_x), 32'd824);

    // Held right: accepted after sync + debounce, then walks to X_MAX and saturates.
    @(posedge clk); #1 right_button = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("db_early", 32'(btn_db[1]), 32'd0);
    repeat (5) @(posedge clk);
    #1 check("db_accept", 32'(btn_db[1]), 32'd1);
    m_right = 1;
    frames(210);
    check("x_max", 32'(player_x), 32'd1648);

    // Both pressed holds; left only walks down to 0 and holds.
    set_pins(1, 1);
    frames(3);
    check("both_hold", 32'(player_x), 32'd1648);
    set_pins(1, 0);
    frames(415);
    check("x_min", 32'(player_x), 32'd0);
    set_pins(0, 0);

    // Full jump arc.
    press_jump();
    frame();
    check("jump_t1_y", 32'(player_y), 32'd0);
    check("jump_t1_air", 32'(airborne), 32'd1);
    frames(12);
    check("apex_y", 32'(player_y), 32'd78);
    frames(11);
    check("last_air_y", 32'(player_y), 32'd12);
    frame();
    check("land_y", 32'(player_y), 32'd0);
    check("land_air", 32'(airborne), 32'd0);

    // Mid-air press is discarded; stays grounded after landing.
    press_jump();
    frames(4);
    check("mid_y", 32'(player_y), 32'd33);
    press_jump();
    frames(21);
    check("land2_air", 32'(airborne), 32'd0);
    frames(3);
    check("stay_ground", 32'(airborne), 32'd0);

    // Reset in the middle of the descent.
    press_jump();
    frames(21);
    check("pre_rst_y", 32'(player_y), 32'd42);
    @(negedge clk) rst = 1'b1;
    #1;
    check("async_x", 32'(player_x), 32'd824);
    check("async_y", 32'(player_y), 32'd0);
    check("async_air", 32'(airborne), 32'd0);
    check("async_strobe", 32'(update_strobe), 32'd0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    s0 = strobe_cnt;
    frames(10);
    repeat (5) @(posedge clk);
    check("strobe_count", 32'(strobe_cnt - s0), 32'd10);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
